// File: rtl/ysyx_23060096_ifu_pkg.sv
// Shared fetch-unit definitions: FSM encoding, the NOP used for fault slots and the reset PC.
// Reused by the IFU, the decoder and the testbench.
package ysyx_23060096_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060096_pc_reg.sv
// Program counter register: reset value, redirect load (highest priority) and +4 step.
module ysyx_23060096_pc_reg
    import ysyx_23060096_ifu_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            incr,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    // Addition wraps naturally at 2^XLEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (incr) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with redirect/kill handling and a
// registered instruction slot presented to decode.
module ysyx_23060096_ifu
    import ysyx_23060096_ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state, state_n;
    logic            kill, kill_n;
    logic            run_q;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_q, inst_pc_q;
    logic            fault_q;
    logic            req_fire, misalign;
    logic            cap_rsp, cap_nop, pc_incr;

    ysyx_23060096_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .incr    (pc_incr),
        .pc      (pc)
    );

    // run_q keeps requests off during the first cycle after reset is sampled; a pending
    // kill blocks new requests until the stale response has drained.
    assign mem_req_valid = run_q && (state == IFU_REQ) && !kill;
    assign mem_req_addr  = pc;
    assign inst_valid    = (state == IFU_HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_fault    = fault_q;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign misalign = redirect_valid && is_misaligned(32'(redirect_pc));

    always_comb begin
        state_n = state;
        kill_n  = kill;
        cap_rsp = 1'b0;
        cap_nop = 1'b0;
        pc_incr = 1'b0;
        // A killed response that shows up after a misaligned redirect left WAIT.
        if (kill && mem_rsp_valid && state != IFU_WAIT) begin
            kill_n = 1'b0;
        end
        case (state)
            IFU_REQ: begin
                if (redirect_valid) begin
                    if (misalign) begin
                        state_n = IFU_HOLD;
                        cap_nop = 1'b1;
                        kill_n  = kill_n | req_fire;
                    end else if (req_fire) begin
                        state_n = IFU_WAIT;
                        kill_n  = 1'b1;
                    end
                end else if (req_fire) begin
                    state_n = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    kill_n = !mem_rsp_valid;
                    if (misalign) begin
                        state_n = IFU_HOLD;
                        cap_nop = 1'b1;
                    end else if (mem_rsp_valid) begin
                        state_n = IFU_REQ;
                    end
                end else if (mem_rsp_valid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = IFU_REQ;
                    end else begin
                        cap_rsp = 1'b1;
                        state_n = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (redirect_valid) begin
                    if (misalign) begin
                        cap_nop = 1'b1;
                    end else begin
                        state_n = IFU_REQ;
                    end
                end else if (inst_ready) begin
                    pc_incr = 1'b1;
                    state_n = IFU_REQ;
                end
            end
            default: begin
                state_n = IFU_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IFU_REQ;
            kill      <= 1'b0;
            run_q     <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
            fault_q   <= 1'b0;
        end else begin
            state <= state_n;
            kill  <= kill_n;
            run_q <= 1'b1;
            if (cap_rsp) begin
                inst_q    <= mem_rsp_data;
                inst_pc_q <= pc;
                fault_q   <= mem_rsp_err;
            end else if (cap_nop) begin
                inst_q    <= XLEN'(NOP_INST);
                inst_pc_q <= redirect_pc;
                fault_q   <= 1'b1;
            end
        end
    end

endmodule
